// File: rtl/ks_addsub_pipe.sv
// ks_addsub_pipe: parametrised pipelined Kogge-Stone adder/subtractor with
// valid/ready flow control and a sideband tag.
// Optional build macro KS_SAT_EN: clamp the result to the signed range on
// overflow instead of wrapping modulo 2^WIDTH.
module ks_addsub_pipe #(
  parameter int WIDTH     = 64,
  parameter int REG_EVERY = 2,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int L2 = $clog2(WIDTH);
  localparam int NP = (L2 + REG_EVERY - 1) / REG_EVERY;

`ifdef KS_SAT_EN
  function automatic logic [WIDTH-1:0] sat_clamp(input logic signed [WIDTH-1:0] s,
                                                 input logic ovf, input logic a_neg);
    logic signed [WIDTH-1:0] lim;
    lim = a_neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    return ovf ? lim : s;
  endfunction
`endif

  // The whole pipe moves as one; a stalled output freezes every stage.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---- stage 0 boundary: generate/propagate, effective carry-in, tag ----
  logic [WIDTH-1:0] b_eff, hs_in, g_in;
  logic             cin_eff;

  // Fold the carry-in into bit 0's generate so the prefix tree yields true carries.
  always_comb begin
    b_eff   = in_sub ? ~in_b : in_b;
    cin_eff = in_cin ^ in_sub;
    hs_in   = in_a ^ b_eff;
    g_in    = in_a & b_eff;
    g_in[0] = g_in[0] | (hs_in[0] & cin_eff);
  end

  logic [WIDTH-1:0] g_p0;
  logic [WIDTH-1:0] hs_p  [NP];
  logic [TAG_W-1:0] tag_p [NP];
  logic [NP-1:0]    ci_p, am_p, bm_p;
  logic [NP-1:0]    vld_p;

  // Data and sideband registers shift with the pipe; they carry no reset.
  always_ff @(posedge clk) begin
    if (adv) begin
      g_p0     <= g_in;
      hs_p[0]  <= hs_in;
      ci_p[0]  <= cin_eff;
      am_p[0]  <= in_a[WIDTH-1];
      bm_p[0]  <= b_eff[WIDTH-1];
      tag_p[0] <= in_tag;
      for (int k = 1; k < NP; k++) begin
        hs_p[k]  <= hs_p[k-1];
        ci_p[k]  <= ci_p[k-1];
        am_p[k]  <= am_p[k-1];
        bm_p[k]  <= bm_p[k-1];
        tag_p[k] <= tag_p[k-1];
      end
    end
  end

  // Valid bits travel with their data and are cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else if (adv) begin
      vld_p[0] <= in_valid;
      for (int k = 1; k < NP; k++) vld_p[k] <= vld_p[k-1];
    end
  end

  // ---- prefix levels: span 1, 2, 4, ..., registered every REG_EVERY levels ----
  for (genvar l = 0; l < L2; l++) begin : g_lvl
    localparam int SP = 1 << l;
    logic [WIDTH-1:0] gi, pi, og;
    if (l == 0) begin : g_src
      assign gi = g_p0;
      assign pi = hs_p[0];
    end else if (l % REG_EVERY == 0) begin : g_src
      logic [WIDTH-1:0] gr, pr;
      // Group boundary register between prefix groups.
      always_ff @(posedge clk) begin
        if (adv) begin
          gr <= g_lvl[l-1].og;
          pr <= g_lvl[l-1].g_pn.op;
        end
      end
      assign gi = gr;
      assign pi = pr;
    end else begin : g_src
      assign gi = g_lvl[l-1].og;
      assign pi = g_lvl[l-1].g_pn.op;
    end
    assign og = gi | (pi & (gi << SP));
    if (l < L2 - 1) begin : g_pn
      localparam logic [WIDTH-1:0] LO = (WIDTH'(1) << SP) - WIDTH'(1);
      logic [WIDTH-1:0] op;
      assign op = pi & ((pi << SP) | LO);
    end
  end

  // ---- final boundary: sum, carry-out, overflow, optional clamp ----
  logic [WIDTH-1:0] g_fin, carry, sum_raw, sum_res;
  logic             cout_c, ovf_c;

  // Carry into bit i is the group generate of bits [i-1:0] (cin for bit 0).
  always_comb begin
    g_fin   = g_lvl[L2-1].og;
    carry   = {g_fin[WIDTH-2:0], ci_p[NP-1]};
    sum_raw = hs_p[NP-1] ^ carry;
    cout_c  = g_fin[WIDTH-1];
    ovf_c   = (am_p[NP-1] == bm_p[NP-1]) && (sum_raw[WIDTH-1] != am_p[NP-1]);
`ifdef KS_SAT_EN
    sum_res = sat_clamp(sum_raw, ovf_c, am_p[NP-1]);
`else
    sum_res = sum_raw;
`endif
  end

  // Output register holds while stalled; reset clears results too.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_tag   <= '0;
    end else if (adv) begin
      out_valid <= vld_p[NP-1];
      out_sum   <= sum_res;
      out_cout  <= cout_c;
      out_ovf   <= ovf_c;
      out_tag   <= tag_p[NP-1];
    end
  end

endmodule
